// File: rtl/exec_pkg.sv
// Shared RV32I/M decode constants, FSM state and md-op encoding for the execute stage.
package exec_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [2:0] {
        MdMul    = 3'b000,
        MdMulh   = 3'b001,
        MdMulhsu = 3'b010,
        MdMulhu  = 3'b011,
        MdDiv    = 3'b100,
        MdDivu   = 3'b101,
        MdRem    = 3'b110,
        MdRemu   = 3'b111
    } md_op_e;

    // MUL counts as signed: the low half of the product is the same either way.
    function automatic logic md_a_signed(input md_op_e op);
        return op inside {MdMul, MdMulh, MdMulhsu, MdDiv, MdRem};
    endfunction

    function automatic logic md_b_signed(input md_op_e op);
        return op inside {MdMul, MdMulh, MdDiv, MdRem};
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes with sign fix-up.
// EXECUTE_MD_FASTMUL_EN replaces the multiply iterations with a single-cycle product.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  md_op_e          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d, negr_q, negr_d, skip_q, skip_d;

    logic              sa, sb, div0;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     sum, rem_t;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem;
`ifdef EXECUTE_MD_FASTMUL_EN
    logic [2*XLEN-1:0] prod_fast;
    assign prod_fast = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    assign sa    = a_i[XLEN-1] & md_a_signed(op_i);
    assign sb    = b_i[XLEN-1] & md_b_signed(op_i);
    assign a_mag = sa ? -a_i : a_i;
    assign b_mag = sb ? -b_i : b_i;
    assign div0  = op_i[2] & (b_i == '0);

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        b_d    = b_q;
        op_d   = op_q;
        neg_d  = neg_q;
        negr_d = negr_q;
        skip_d = skip_q;
        sum    = '0;
        rem_t  = '0;
        if (start_i) begin
            op_d   = op_i;
            b_d    = b_mag;
            hi_d   = '0;
            lo_d   = a_mag;
            neg_d  = sa ^ sb;
            negr_d = sa;
            skip_d = 1'b0;
            cnt_d  = CW'(XLEN);
            if (div0) begin
                // Result is fixed up front; the single BUSY cycle just counts down.
                hi_d   = a_i;
                lo_d   = '1;
                neg_d  = 1'b0;
                negr_d = 1'b0;
                skip_d = 1'b1;
                cnt_d  = CW'(1);
            end
`ifdef EXECUTE_MD_FASTMUL_EN
            if (!op_i[2]) begin
                {hi_d, lo_d} = prod_fast;
                cnt_d        = '0;
            end
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (!skip_q) begin
                if (!op_q[2]) begin
                    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
                    hi_d = sum[XLEN:1];
                    lo_d = {sum[0], lo_q[XLEN-1:1]};
                end else begin
                    rem_t = {hi_q, lo_q[XLEN-1]};
                    if (rem_t >= {1'b0, b_q}) begin
                        rem_t = rem_t - {1'b0, b_q};
                        lo_d  = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        lo_d  = {lo_q[XLEN-2:0], 1'b0};
                    end
                    hi_d = rem_t[XLEN-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            op_q   <= MdMul;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
            skip_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
            op_q   <= op_d;
            neg_q  <= neg_d;
            negr_q <= negr_d;
            skip_q <= skip_d;
        end
    end

    assign done_o = (cnt_q == CW'(1));
    assign prod   = {hi_q, lo_q};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = neg_q ? -lo_q : lo_q;
    assign rem    = negr_q ? -hi_q : hi_q;

    always_comb begin
        unique case (op_q)
            MdMul:                     result_o = prod_s[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: result_o = prod_s[2*XLEN-1:XLEN];
            MdDiv, MdDivu:             result_o = quo;
            default:                   result_o = rem;
        endcase
    end

endmodule

// File: rtl/execute_md.sv
// Execute stage: single-cycle RV32I ALU/branch/address path plus a stalling M-extension engine.
// EXECUTE_MD_FASTMUL_EN selects single-cycle multiplies.
module execute_md
    import exec_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            valid_ro,
    input  logic            ready_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] r0data_i,
    input  logic [XLEN-1:0] r1data_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [31:0]     inst_ro,
    output logic [XLEN-1:0] r0data_ro,
    output logic [XLEN-1:0] r1data_ro,
    output logic [XLEN-1:0] result_ro,
    output logic [XLEN-1:0] jumpaddr_o,
    output logic            jumptaken_o,
    output logic [XLEN-1:0] datamemaddr_o,
    output logic [XLEN-1:0] datamemdata_o,
    output logic            datamemwrite_o,
    output logic [1:0]      datamemwidth_o,
    output logic            busy_o
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, op_b, alu_res, base_res, md_result;
    logic [SHW-1:0]  shamt;
    logic            is_md, md_pending, cke, br_cond, md_start, md_done, fast_mul;
    state_e          state_q, state_d;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = XLEN'($signed(inst_i[31:20]));
    assign imm_s  = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b  = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));

    assign is_md      = (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);
    assign md_pending = valid_i & is_md;
    assign cke        = ~valid_ro | ready_i;
`ifdef EXECUTE_MD_FASTMUL_EN
    assign fast_mul = ~funct3[2];
`else
    assign fast_mul = 1'b0;
`endif

    assign op_b  = (opcode == OPC_OP) ? r1data_i : imm_i;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        unique case (funct3)
            F3_ADD:  alu_res = (opcode == OPC_OP && funct7[5]) ? r0data_i - op_b
                                                               : r0data_i + op_b;
            F3_SLL:  alu_res = r0data_i << shamt;
            F3_SLT:  alu_res = XLEN'($signed(r0data_i) < $signed(op_b));
            F3_SLTU: alu_res = XLEN'(r0data_i < op_b);
            F3_XOR:  alu_res = r0data_i ^ op_b;
            F3_SR:   alu_res = funct7[5] ? $unsigned($signed(r0data_i) >>> shamt)
                                         : r0data_i >> shamt;
            F3_OR:   alu_res = r0data_i | op_b;
            default: alu_res = r0data_i & op_b;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_OPIMM, OPC_OP: base_res = alu_res;
            OPC_LUI:           base_res = imm_u;
            OPC_AUIPC:         base_res = pc_i + imm_u;
            OPC_JAL, OPC_JALR: base_res = pc_i + XLEN'(4);
            default:           base_res = '1;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BEQ:  br_cond = (r0data_i == r1data_i);
            F3_BNE:  br_cond = (r0data_i != r1data_i);
            F3_BLT:  br_cond = ($signed(r0data_i) < $signed(r1data_i));
            F3_BGE:  br_cond = ($signed(r0data_i) >= $signed(r1data_i));
            F3_BLTU: br_cond = (r0data_i < r1data_i);
            F3_BGEU: br_cond = (r0data_i >= r1data_i);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_JAL:  jumpaddr_o = pc_i + imm_j;
            OPC_JALR: jumpaddr_o = (r0data_i + imm_i) & ~XLEN'(1);
            default:  jumpaddr_o = pc_i + imm_b;
        endcase
    end

    assign jumptaken_o    = ready_o & valid_i & ((opcode == OPC_JAL) | (opcode == OPC_JALR) |
                                                 ((opcode == OPC_BRANCH) & br_cond));
    assign datamemaddr_o  = r0data_i + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign datamemdata_o  = r1data_i;
    assign datamemwrite_o = ready_o & valid_i & (opcode == OPC_STORE);
    assign datamemwidth_o = funct3[1:0];

    muldiv_iter #(
        .XLEN(XLEN)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .op_i    (md_op_e'(funct3)),
        .a_i     (r0data_i),
        .b_i     (r1data_i),
        .done_o  (md_done),
        .result_o(md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (md_pending) state_d = fast_mul ? DONE : BUSY;
            BUSY:    if (md_done) state_d = DONE;
            DONE:    if (cke) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        md_start = (state_q == IDLE) & md_pending;
        busy_o   = (state_q != IDLE);
        ready_o  = cke & (((state_q == IDLE) & ~md_pending) | (state_q == DONE));
    end

    // ready_o already implies cke; it doubles as the output-register load enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ro  <= 1'b0;
            pc_ro     <= '0;
            inst_ro   <= '0;
            r0data_ro <= '0;
            r1data_ro <= '0;
            result_ro <= '0;
        end else if (cke) begin
            valid_ro <= ready_o & (valid_i | (state_q == DONE));
            if (ready_o) begin
                pc_ro     <= pc_i;
                inst_ro   <= inst_i;
                r0data_ro <= r0data_i;
                r1data_ro <= r1data_i;
                result_ro <= (state_q == DONE) ? md_result : base_res;
            end
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Scoreboard bench for execute_md: ALU stream, branches/stores, M ops, stalls and reset abort.
module tb_execute_md;
    logic        clk, rst, valid_i, ready_o, valid_ro, ready_i;
    logic [31:0] pc_i, inst_i, r0data_i, r1data_i;
    logic [31:0] pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro;
    logic [31:0] jumpaddr_o, datamemaddr_o, datamemdata_o;
    logic        jumptaken_o, datamemwrite_o, busy_o;
    logic [1:0]  datamemwidth_o;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

`ifdef EXECUTE_MD_FASTMUL_EN
    localparam int MulLat = 1;
`else
    localparam int MulLat = 33;
`endif

    execute_md #(.XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .valid_ro      (valid_ro),
        .ready_i       (ready_i),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .r0data_i      (r0data_i),
        .r1data_i      (r1data_i),
        .pc_ro         (pc_ro),
        .inst_ro       (inst_ro),
        .r0data_ro     (r0data_ro),
        .r1data_ro     (r1data_ro),
        .result_ro     (result_ro),
        .jumpaddr_o    (jumpaddr_o),
        .jumptaken_o   (jumptaken_o),
        .datamemaddr_o (datamemaddr_o),
        .datamemdata_o (datamemdata_o),
        .datamemwrite_o(datamemwrite_o),
        .datamemwidth_o(datamemwidth_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                           input logic [6:0] op);
        return {imm, 5'd1, f3, 5'd3, op};
    endfunction
    function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    // Presents one op and waits for acceptance; counts ready_o-low and busy_o-high cycles.
    task automatic run_op(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                          output int lowcnt, output int busycnt);
        @(posedge clk); #1;
        pc_i = 32'h100; inst_i = inst; r0data_i = a; r1data_i = b; valid_i = 1'b1;
        lowcnt = 0; busycnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (busy_o) busycnt++;
            if (ready_o) break;
            lowcnt++;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        pc_i = '0; inst_i = '0; r0data_i = '0; r1data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (valid_ro !== 1'b0 || result_ro !== 32'h0 || pc_ro !== 32'h0) begin
            bad++; $display("FAIL reset_outputs got v=%b r=%h pc=%h want 0", valid_ro, result_ro, pc_ro);
        end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy_o); end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready_o); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ti[13], ta[13], tb[13], te[13];
        ti[0]  = i_type(12'hFFD, 3'b000, 7'b0010011); ta[0]  = 5;            tb[0]  = 0;            te[0]  = 2;
        ti[1]  = r_type(7'h00, 3'b000);               ta[1]  = 10;           tb[1]  = 20;           te[1]  = 30;
        ti[2]  = r_type(7'h20, 3'b000);               ta[2]  = 5;            tb[2]  = 7;            te[2]  = 32'hFFFFFFFE;
        ti[3]  = r_type(7'h00, 3'b001);               ta[3]  = 1;            tb[3]  = 35;           te[3]  = 8;
        ti[4]  = r_type(7'h20, 3'b101);               ta[4]  = 32'h80000000; tb[4]  = 4;            te[4]  = 32'hF8000000;
        ti[5]  = r_type(7'h00, 3'b010);               ta[5]  = 32'hFFFFFFFF; tb[5]  = 1;            te[5]  = 1;
        ti[6]  = r_type(7'h00, 3'b011);               ta[6]  = 1;            tb[6]  = 32'hFFFFFFFF; te[6]  = 1;
        ti[7]  = i_type(12'h0FF, 3'b100, 7'b0010011); ta[7]  = 32'h0F0F0F0F; tb[7]  = 0;            te[7]  = 32'h0F0F0FF0;
        ti[8]  = {20'h12345, 5'd3, 7'b0110111};       ta[8]  = 0;            tb[8]  = 0;            te[8]  = 32'h12345000;
        ti[9]  = {20'h00001, 5'd3, 7'b0010111};       ta[9]  = 0;            tb[9]  = 0;            te[9]  = 32'h1100;
        ti[10] = {20'h00000, 5'd1, 7'b1101111};       ta[10] = 0;            tb[10] = 0;            te[10] = 32'h104;
        ti[11] = i_type(12'h004, 3'b101, 7'b0010011); ta[11] = 32'h80000000; tb[11] = 0;            te[11] = 32'h08000000;
        ti[12] = i_type(12'h404, 3'b101, 7'b0010011); ta[12] = 32'h80000000; tb[12] = 0;            te[12] = 32'hF8000000;
        @(posedge clk); #1;
        for (int i = 0; i < 13; i++) begin
            pc_i = 32'h100; inst_i = ti[i]; r0data_i = ta[i]; r1data_i = tb[i]; valid_i = 1'b1;
            exp_q.push_back(te[i]);
            @(negedge clk);
            total++;
            if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, ready_o); end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if (valid_ro !== 1'b1 || result_ro !== e) begin
                bad++; $display("FAIL b2b_result[%0d] got v=%b %h want v=1 %h", i, valid_ro, result_ro, e);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_branch;
        logic [31:0] ti[6], ta[6], tb[6], ja[6];
        logic        tk[6], wr[6];
        ti[0] = b_type(13'd16, 3'b100); ta[0] = 32'hFFFFFFFF; tb[0] = 1; tk[0] = 1; wr[0] = 0; ja[0] = 32'h110;
        ti[1] = b_type(13'd16, 3'b101); ta[1] = 32'hFFFFFFFF; tb[1] = 1; tk[1] = 0; wr[1] = 0; ja[1] = 32'h110;
        ti[2] = b_type(13'd16, 3'b110); ta[2] = 32'hFFFFFFFF; tb[2] = 1; tk[2] = 0; wr[2] = 0; ja[2] = 32'h110;
        ti[3] = b_type(13'd16, 3'b000); ta[3] = 3;            tb[3] = 3; tk[3] = 1; wr[3] = 0; ja[3] = 32'h110;
        ti[4] = s_type(12'h008, 3'b010); ta[4] = 32'h2000;    tb[4] = 32'hDEADBEEF; tk[4] = 0; wr[4] = 1;
        ja[4] = 0;
        ti[5] = i_type(12'h011, 3'b000, 7'b1100111); ta[5] = 32'h200; tb[5] = 0; tk[5] = 1; wr[5] = 0;
        ja[5] = 32'h210;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            pc_i = 32'h100; inst_i = ti[i]; r0data_i = ta[i]; r1data_i = tb[i]; valid_i = 1'b1;
            exp_q.push_back(i == 5 ? 32'h104 : 32'hFFFFFFFF);
            @(negedge clk);
            total++;
            if (jumptaken_o !== tk[i] || datamemwrite_o !== wr[i]) begin
                bad++; $display("FAIL branch_flags[%0d] got tk=%b wr=%b want tk=%b wr=%b",
                                i, jumptaken_o, datamemwrite_o, tk[i], wr[i]);
            end
            if (i == 4) begin
                total++;
                if (datamemaddr_o !== 32'h2008 || datamemdata_o !== 32'hDEADBEEF ||
                    datamemwidth_o !== 2'd2) begin
                    bad++; $display("FAIL store_path got a=%h d=%h w=%0d want 2008 deadbeef 2",
                                    datamemaddr_o, datamemdata_o, datamemwidth_o);
                end
            end else begin
                total++;
                if (jumpaddr_o !== ja[i]) begin
                    bad++; $display("FAIL jumpaddr[%0d] got %h want %h", i, jumpaddr_o, ja[i]);
                end
            end
            @(posedge clk); #1;
            e = exp_q.pop_front();
            total++;
            if (valid_ro !== 1'b1 || result_ro !== e) begin
                bad++; $display("FAIL branch_result[%0d] got v=%b %h want v=1 %h", i, valid_ro, result_ro, e);
            end
        end
        inst_i = ti[0]; r0data_i = ta[0]; r1data_i = tb[0]; valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (jumptaken_o !== 1'b0) begin bad++; $display("FAIL taken_unqualified got %b want 0", jumptaken_o); end
    endtask

    task automatic test_mul;
        logic [2:0]  f3[6];
        logic [31:0] ta[6], tb[6], te[6];
        int          lc, bc;
        f3[0] = 3'b000; ta[0] = 7;            tb[0] = 32'hFFFFFFFD; te[0] = 32'hFFFFFFEB;
        f3[1] = 3'b011; ta[1] = 32'hFFFFFFFF; tb[1] = 32'hFFFFFFFF; te[1] = 32'hFFFFFFFE;
        f3[2] = 3'b001; ta[2] = 32'h80000000; tb[2] = 32'h80000000; te[2] = 32'h40000000;
        f3[3] = 3'b010; ta[3] = 32'hFFFFFFFF; tb[3] = 32'hFFFFFFFF; te[3] = 32'hFFFFFFFF;
        f3[4] = 3'b001; ta[4] = 32'hFFFFFFFF; tb[4] = 32'hFFFFFFFF; te[4] = 32'h0;
        f3[5] = 3'b000; ta[5] = 32'h12345678; tb[5] = 32'h10;       te[5] = 32'h23456780;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(te[i]);
            run_op(r_type(7'h01, f3[i]), ta[i], tb[i], lc, bc);
            e = exp_q.pop_front();
            total++;
            if (valid_ro !== 1'b1 || result_ro !== e) begin
                bad++; $display("FAIL mul_result[%0d] got v=%b %h want v=1 %h", i, valid_ro, result_ro, e);
            end
            total++;
            if (lc != MulLat || bc != MulLat) begin
                bad++; $display("FAIL mul_latency[%0d] got low=%0d busy=%0d want %0d", i, lc, bc, MulLat);
            end
        end
    endtask

    task automatic test_div;
        logic [2:0]  f3[11];
        logic [31:0] ta[11], tb[11], te[11];
        int          tl[11];
        int          lc, bc;
        f3[0]  = 3'b100; ta[0]  = 32'hFFFFFFF9; tb[0]  = 2;            te[0]  = 32'hFFFFFFFD; tl[0]  = 33;
        f3[1]  = 3'b110; ta[1]  = 32'hFFFFFFF9; tb[1]  = 2;            te[1]  = 32'hFFFFFFFF; tl[1]  = 33;
        f3[2]  = 3'b101; ta[2]  = 100;          tb[2]  = 7;            te[2]  = 14;           tl[2]  = 33;
        f3[3]  = 3'b111; ta[3]  = 100;          tb[3]  = 7;            te[3]  = 2;            tl[3]  = 33;
        f3[4]  = 3'b101; ta[4]  = 32'hFFFFFFFF; tb[4]  = 1;            te[4]  = 32'hFFFFFFFF; tl[4]  = 33;
        f3[5]  = 3'b110; ta[5]  = 7;            tb[5]  = 32'hFFFFFFFE; te[5]  = 1;            tl[5]  = 33;
        f3[6]  = 3'b100; ta[6]  = 5;            tb[6]  = 0;            te[6]  = 32'hFFFFFFFF; tl[6]  = 2;
        f3[7]  = 3'b110; ta[7]  = 5;            tb[7]  = 0;            te[7]  = 5;            tl[7]  = 2;
        f3[8]  = 3'b111; ta[8]  = 32'hFFFFFFF9; tb[8]  = 0;            te[8]  = 32'hFFFFFFF9; tl[8]  = 2;
        f3[9]  = 3'b100; ta[9]  = 32'h80000000; tb[9]  = 32'hFFFFFFFF; te[9]  = 32'h80000000; tl[9]  = 33;
        f3[10] = 3'b110; ta[10] = 32'h80000000; tb[10] = 32'hFFFFFFFF; te[10] = 0;            tl[10] = 33;
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(te[i]);
            run_op(r_type(7'h01, f3[i]), ta[i], tb[i], lc, bc);
            e = exp_q.pop_front();
            total++;
            if (valid_ro !== 1'b1 || result_ro !== e) begin
                bad++; $display("FAIL div_result[%0d] got v=%b %h want v=1 %h", i, valid_ro, result_ro, e);
            end
            total++;
            if (lc != tl[i] || bc != tl[i]) begin
                bad++; $display("FAIL div_latency[%0d] got low=%0d busy=%0d want %0d", i, lc, bc, tl[i]);
            end
        end
    endtask

    task automatic test_stall;
        @(posedge clk); #1;
        ready_i = 1'b0;
        pc_i = 32'h100; inst_i = i_type(12'h00C, 3'b000, 7'b0010011); r0data_i = 30;
        valid_i = 1'b1;
        exp_q.push_back(32'd42);
        @(posedge clk); #1;
        inst_i = r_type(7'h01, 3'b101); r0data_i = 100; r1data_i = 7;
        exp_q.push_back(32'd14);
        repeat (40) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0 || valid_ro !== 1'b1 || result_ro !== exp_q[0]) begin
                bad++; $display("FAIL stall_hold[%0d] got busy=%b rdy=%b v=%b r=%h want 1 0 1 %h",
                                i, busy_o, ready_o, valid_ro, result_ro, exp_q[0]);
            end
        end
        @(posedge clk); #1;
        ready_i = 1'b1;
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (ready_o !== 1'b1 || result_ro !== e) begin
            bad++; $display("FAIL stall_release got rdy=%b r=%h want 1 %h", ready_o, result_ro, e);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (valid_ro !== 1'b1 || result_ro !== e || busy_o !== 1'b0) begin
            bad++; $display("FAIL stall_result got v=%b r=%h busy=%b want 1 %h 0",
                            valid_ro, result_ro, busy_o, e);
        end
    endtask

    task automatic test_rst_mid_busy;
        int lc, bc;
        @(posedge clk); #1;
        pc_i = 32'h100; inst_i = r_type(7'h01, 3'b100); r0data_i = 32'hFFFFFFF9; r1data_i = 2;
        valid_i = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL pre_rst_busy got %b want 1", busy_o); end
        rst = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || valid_ro !== 1'b0) begin
            bad++; $display("FAIL rst_abort got busy=%b v=%b want 0 0", busy_o, valid_ro);
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(32'hFFFFFFFD);
        run_op(r_type(7'h01, 3'b100), 32'hFFFFFFF9, 2, lc, bc);
        e = exp_q.pop_front();
        total++;
        if (valid_ro !== 1'b1 || result_ro !== e || lc != 33) begin
            bad++; $display("FAIL rst_replay got v=%b r=%h low=%0d want 1 %h 33", valid_ro, result_ro, lc, e);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_branch();
        test_mul();
        test_div();
        test_stall();
        test_rst_mid_busy();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
